// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port RAM.
// Data side has priority; fetch is forced through after STARVE_LIMIT denials.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    owner_t     owner;
    logic       force_if;

    assign force_if = if_req && (starve_cnt == LIMIT);

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!clear) begin
            if (force_if) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            mem_data = d_wdata;
            mem_we   = d_we;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            starve_cnt <= 4'd0;
            owner      <= OWN_NONE;
        end else begin
            if (if_gnt || !if_req) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (if_gnt) begin
                owner <= OWN_IF;
            end else if (d_gnt && !d_we) begin
                owner <= OWN_D;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

    // A response due in a cycle where clear is high is dropped.
    assign if_rvalid = (owner == OWN_IF) && !clear;
    assign d_rvalid  = (owner == OWN_D) && !clear;
    assign if_rdata  = if_rvalid ? mem_q : '0;
    assign d_rdata   = d_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, shadow memory and a
// response scoreboard keyed by the cycle each read is due.
module tb_mem_arbiter;

    logic        clock;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_q;

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .clear(clear),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .mem_q(mem_q)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] ram[0:255];
    logic [31:0] shadow[0:255];
    int          cyc;
    int          total;
    int          bad;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr[9:2]] <= mem_data;
        mem_q <= ram[mem_addr[9:2]];
    end

    // Scoreboard: pop the response due this cycle and compare.
    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            resp_t r;
            r = sb.pop_front();
            total++;
            bad++;
            $display("FAIL sb_stale: response due cycle %0d never seen (now %0d)", r.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            resp_t r;
            r = sb.pop_front();
            total++;
            if (clear) begin
                if ({if_rvalid, d_rvalid} !== 2'b00) begin
                    bad++;
                    $display("FAIL sb_discard: rvalid if/d=%b%b required 00", if_rvalid, d_rvalid);
                end
            end else if (r.is_d) begin
                if ({d_rvalid, if_rvalid, d_rdata, if_rdata} !== {2'b10, r.data, 32'h0}) begin
                    bad++;
                    $display("FAIL sb_d: rvalid d/if=%b%b rdata d=%h if=%h required 10 %h 0",
                             d_rvalid, if_rvalid, d_rdata, if_rdata, r.data);
                end
            end else begin
                if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {2'b10, r.data, 32'h0}) begin
                    bad++;
                    $display("FAIL sb_if: rvalid if/d=%b%b rdata if=%h d=%h required 10 %h 0",
                             if_rvalid, d_rvalid, if_rdata, d_rdata, r.data);
                end
            end
        end else begin
            total++;
            if ({if_rvalid, d_rvalid} !== 2'b00) begin
                bad++;
                $display("FAIL sb_spurious: rvalid if/d=%b%b required 00 at cycle %0d",
                         if_rvalid, d_rvalid, cyc);
            end
        end
    end

    task automatic push(input bit is_d, input logic [31:0] addr);
        resp_t r;
        r.is_d = is_d;
        r.data = shadow[addr[9:2]];
        r.due  = cyc + 1;
        sb.push_back(r);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear  = 1'b1;
        if_req = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if ({if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid} !== 5'b0) begin
                bad++;
                $display("FAIL reset_hold: gnt if/d=%b%b we=%b rvalid=%b%b required 00000",
                         if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid);
            end
            if (i < 2) step();
        end
        step();
        clear  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        @(negedge clock);
        total++;
        if ({if_rvalid, d_rvalid, mem_we, mem_addr, mem_data} !== 67'b0) begin
            bad++;
            $display("FAIL reset_after: rvalid=%b%b we=%b addr=%h data=%h required all 0",
                     if_rvalid, d_rvalid, mem_we, mem_addr, mem_data);
        end
    endtask

    task automatic test_if_only();
        step();
        if_req  = 1'b1;
        if_addr = 32'h10;
        @(negedge clock);
        total++;
        if ({if_gnt, d_gnt, mem_we, mem_addr} !== {3'b100, 32'h10}) begin
            bad++;
            $display("FAIL if_only_gnt: gnt=%b%b we=%b addr=%h required 100 00000010",
                     if_gnt, d_gnt, mem_we, mem_addr);
        end
        push(1'b0, if_addr);
        step();
        if_req = 1'b0;
        @(negedge clock);
        total++;
        if (if_rdata !== 32'h00500093) begin
            bad++;
            $display("FAIL if_only_data: if_rdata=%h required 00500093", if_rdata);
        end
    endtask

    task automatic test_contention();
        step();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h200;
        if_req  = 1'b1;
        if_addr = 32'h14;
        @(negedge clock);
        total++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 32'h200}) begin
            bad++;
            $display("FAIL cont_d_first: gnt d/if=%b%b addr=%h required 10 00000200",
                     d_gnt, if_gnt, mem_addr);
        end
        push(1'b1, d_addr);
        step();
        d_req = 1'b0;
        @(negedge clock);
        total++;
        if ({if_gnt, d_gnt, mem_addr, d_rdata} !== {2'b10, 32'h14, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL cont_if_next: gnt if/d=%b%b addr=%h d_rdata=%h required 10 00000014 deadbeef",
                     if_gnt, d_gnt, mem_addr, d_rdata);
        end
        push(1'b0, if_addr);
        step();
        if_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_starvation();
        step();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h200;
        if_req  = 1'b1;
        if_addr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            bit want_if;
            want_if = (i == 4) || (i == 9);
            @(negedge clock);
            total++;
            if ({if_gnt, d_gnt} !== {want_if, !want_if}) begin
                bad++;
                $display("FAIL starve_%0d: gnt if/d=%b%b required %b%b",
                         i, if_gnt, d_gnt, want_if, !want_if);
            end
            push(!want_if, want_if ? if_addr : d_addr);
            step();
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h12345678;
        @(negedge clock);
        total++;
        if ({d_gnt, mem_we, mem_addr, mem_data} !== {2'b11, 32'h40, 32'h12345678}) begin
            bad++;
            $display("FAIL wr_drive: gnt=%b we=%b addr=%h data=%h required 1 1 00000040 12345678",
                     d_gnt, mem_we, mem_addr, mem_data);
        end
        shadow[16] = d_wdata;
        step();
        d_we = 1'b0;
        @(negedge clock);
        total++;
        if ({d_gnt, mem_we, d_rvalid} !== 3'b100) begin
            bad++;
            $display("FAIL rd_issue: gnt=%b we=%b d_rvalid=%b required 100",
                     d_gnt, mem_we, d_rvalid);
        end
        push(1'b1, d_addr);
        step();
        d_req = 1'b0;
        @(negedge clock);
        total++;
        if (d_rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL rd_data: d_rdata=%h required 12345678", d_rdata);
        end
    endtask

    task automatic test_clear_mid_read();
        step();
        if_req  = 1'b1;
        if_addr = 32'h10;
        @(negedge clock);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL clr_gnt: if_gnt=%b required 1", if_gnt);
        end
        push(1'b0, if_addr);
        step();
        clear = 1'b1;
        @(negedge clock);
        total++;
        if ({if_rvalid, if_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL clr_drop: if_rvalid=%b if_gnt=%b required 00", if_rvalid, if_gnt);
        end
        step();
        clear = 1'b0;
        @(negedge clock);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL clr_regrant: if_gnt=%b required 1", if_gnt);
        end
        push(1'b0, if_addr);
        step();
        if_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'(i) * 32'h01010101;
            shadow[i] = 32'(i) * 32'h01010101;
        end
        ram[4]      = 32'h00500093;
        shadow[4]   = 32'h00500093;
        ram[128]    = 32'hDEADBEEF;
        shadow[128] = 32'hDEADBEEF;
        cyc     = 0;
        total   = 0;
        bad     = 0;
        clear   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset();
        test_if_only();
        test_contention();
        test_starvation();
        test_write_read();
        test_clear_mid_read();
        repeat (3) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
